mdr_ctrl: RTL

- Parametrised memory data register with a built-in memory handshake controller.
- Loads from the CPU bus, or issues a memory read/write and waits for the memory response.
- Read data is lane-selected and sign- or zero-extended for byte, half and full loads before it is captured.
- Sits between the internal bus mux and the memory/RAM port, and replaces the fixed-width MDR.

---
 rtl/mdr_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/mdr_ctrl.sv
// Memory data register with a memory read/write handshake controller and load extraction.
// Optional define MDR_BYPASS_EN adds a combinational read-data forward path (rd_fwd, rd_fwd_valid).
module mdr_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4,
  localparam int unsigned OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] busMuxOut,
  input  logic              MDRin,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [OFF_W-1:0]  byte_off,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              mem_ready,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] MDRout,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef MDR_BYPASS_EN
  ,
  output logic [DATA_W-1:0] rd_fwd,
  output logic              rd_fwd_valid
`endif
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t            state;
  logic [TO_W-1:0]   cnt;
  logic [7:0]        b_lane;
  logic [15:0]       h_lane;
  logic [DATA_W-1:0] ext;
  logic              expired;

  // Lane select plus sign/zero extension of the memory read word
  always_comb begin
    b_lane = 8'(mem_rdata >> {byte_off, 3'b000});
    h_lane = 16'(mem_rdata >> {byte_off[OFF_W-1:1], 4'b0000});
    case (size)
      2'b00:   ext = {{(DATA_W-8){sext & b_lane[7]}}, b_lane};
      2'b01:   ext = {{(DATA_W-16){sext & h_lane[15]}}, h_lane};
      default: ext = mem_rdata;
    endcase
  end

  assign expired = (cnt == TO_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      cnt    <= '0;
      MDRout <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (read_req) begin
            state <= RD_WAIT;
            cnt   <= '0;
          end else if (write_req) begin
            state <= WR_WAIT;
            cnt   <= '0;
          end else if (MDRin) begin
            MDRout <= busMuxOut;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            MDRout <= ext;
            done   <= 1'b1;
            state  <= IDLE;
          end else if (expired) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        WR_WAIT: begin
          // MDRout stays frozen so mem_wdata is stable for the whole write
          if (mem_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (expired) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign mem_rd    = (state == RD_WAIT);
  assign mem_wr    = (state == WR_WAIT);
  assign mem_wdata = MDRout;

`ifdef MDR_BYPASS_EN
  assign rd_fwd       = ext;
  assign rd_fwd_valid = (state == RD_WAIT) && mem_rvalid;
`endif

endmodule
